// File: rtl/sort_pkg.sv
// Shared constants for the sequential weight sorter: FSM encoding, default lane geometry, counter sizing.
// No logic of its own; imported by the sorter top and its compare-and-swap cell.
package sort_pkg;

  localparam int NUM_DEF      = 8;
  localparam int CHAR_W_DEF   = 4;
  localparam int WEIGHT_W_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Pass counter must be able to hold the value NUM itself.
  function automatic int pass_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// One compare-and-swap cell: orders a (char, weight) pair by unsigned weight; combinational, 0 cycles.
// No handshake; equal weights never swap so the lower lane keeps priority.
module sort_cmp_swap #(
  parameter int CHAR_W   = 4,
  parameter int WEIGHT_W = 5
) (
  input  logic [CHAR_W-1:0]   a_chr,
  input  logic [WEIGHT_W-1:0] a_wgt,
  input  logic [CHAR_W-1:0]   b_chr,
  input  logic [WEIGHT_W-1:0] b_wgt,
  input  logic                descend,
  output logic [CHAR_W-1:0]   lo_chr,
  output logic [WEIGHT_W-1:0] lo_wgt,
  output logic [CHAR_W-1:0]   hi_chr,
  output logic [WEIGHT_W-1:0] hi_wgt,
  output logic                swapped
);

  assign swapped = descend ? (a_wgt < b_wgt) : (a_wgt > b_wgt);

  assign lo_chr = swapped ? b_chr : a_chr;
  assign lo_wgt = swapped ? b_wgt : a_wgt;
  assign hi_chr = swapped ? a_chr : b_chr;
  assign hi_wgt = swapped ? a_wgt : b_wgt;

endmodule

// File: rtl/seq_sort_ip.sv
// Iterative odd-even transposition sorter of NUM (char, weight) lanes, stable, early exit; 2..NUM passes.
// Single request in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_sort_ip
  import sort_pkg::*;
#(
  parameter int NUM      = NUM_DEF,
  parameter int CHAR_W   = CHAR_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM*CHAR_W-1:0]        in_character,
  input  logic [NUM*WEIGHT_W-1:0]      in_weight,
  input  logic                         in_descend,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM*CHAR_W-1:0]        out_character,
  output logic [NUM*WEIGHT_W-1:0]      out_weight
);

  localparam int PW = pass_cnt_w(NUM);
  localparam logic [PW-1:0] PASS_MAX = PW'(NUM);
  localparam logic [PW-1:0] PASS_MIN = PW'(2);

  logic [1:0]          state;
  logic [PW-1:0]       pass_cnt;
  logic [PW-1:0]       pass_nxt;
  logic                prev_swap;
  logic                descend_q;
  logic                any_swap;
  logic                sort_done;

  logic [CHAR_W-1:0]   chr_q   [NUM];
  logic [WEIGHT_W-1:0] wgt_q   [NUM];
  logic [CHAR_W-1:0]   chr_nxt [NUM];
  logic [WEIGHT_W-1:0] wgt_nxt [NUM];

  logic [CHAR_W-1:0]   lo_chr  [NUM-1];
  logic [WEIGHT_W-1:0] lo_wgt  [NUM-1];
  logic [CHAR_W-1:0]   hi_chr  [NUM-1];
  logic [WEIGHT_W-1:0] hi_wgt  [NUM-1];
  logic                swp     [NUM-1];

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);

  for (genvar j = 0; j < NUM - 1; j++) begin : g_cell
    sort_cmp_swap #(
      .CHAR_W   (CHAR_W),
      .WEIGHT_W (WEIGHT_W)
    ) u_cell (
      .a_chr   (chr_q[j]),
      .a_wgt   (wgt_q[j]),
      .b_chr   (chr_q[j+1]),
      .b_wgt   (wgt_q[j+1]),
      .descend (descend_q),
      .lo_chr  (lo_chr[j]),
      .lo_wgt  (lo_wgt[j]),
      .hi_chr  (hi_chr[j]),
      .hi_wgt  (hi_wgt[j]),
      .swapped (swp[j])
    );
  end

  // Even passes use cells 0,2,4..; odd passes use 1,3,5..; the active cells never share a lane.
  always_comb begin
    any_swap = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      chr_nxt[i] = chr_q[i];
      wgt_nxt[i] = wgt_q[i];
    end
    for (int j = 0; j < NUM - 1; j++) begin
      if (j[0] == pass_cnt[0]) begin
        chr_nxt[j]   = lo_chr[j];
        wgt_nxt[j]   = lo_wgt[j];
        chr_nxt[j+1] = hi_chr[j];
        wgt_nxt[j+1] = hi_wgt[j];
        any_swap     = any_swap | swp[j];
      end
    end
  end

  // Two consecutive quiet passes (one odd, one even) prove the lanes are ordered.
  assign pass_nxt  = pass_cnt + PW'(1);
  assign sort_done = (pass_nxt == PASS_MAX) ||
                     ((pass_nxt >= PASS_MIN) && !any_swap && !prev_swap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pass_cnt  <= '0;
      prev_swap <= 1'b0;
      descend_q <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        chr_q[i] <= '0;
        wgt_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM; i++) begin
              chr_q[i] <= in_character[(NUM-1-i)*CHAR_W +: CHAR_W];
              wgt_q[i] <= in_weight[(NUM-1-i)*WEIGHT_W +: WEIGHT_W];
            end
            descend_q <= in_descend;
            pass_cnt  <= '0;
            prev_swap <= 1'b1;
            state     <= ST_SORT;
          end
        end
        ST_SORT: begin
          for (int i = 0; i < NUM; i++) begin
            chr_q[i] <= chr_nxt[i];
            wgt_q[i] <= wgt_nxt[i];
          end
          pass_cnt  <= pass_nxt;
          prev_swap <= any_swap;
          if (sort_done) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Lane registers are only exposed once the result is final.
  always_comb begin
    out_character = '0;
    out_weight    = '0;
    if (state == ST_DONE) begin
      for (int i = 0; i < NUM; i++) begin
        out_character[(NUM-1-i)*CHAR_W +: CHAR_W]     = chr_q[i];
        out_weight[(NUM-1-i)*WEIGHT_W +: WEIGHT_W]    = wgt_q[i];
      end
    end
  end

endmodule

// File: tb/tb_seq_sort_ip.sv
// Directed + scoreboard bench for seq_sort_ip at NUM=8, CHAR_W=4, WEIGHT_W=5.
module tb_seq_sort_ip;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_character;
  logic [39:0] in_weight;
  logic        in_descend;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_character;
  logic [39:0] out_weight;

  typedef struct {
    logic [31:0] chr;
    logic [39:0] wgt;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;

  seq_sort_ip #(.NUM(8), .CHAR_W(4), .WEIGHT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_character  (in_character),
    .in_weight     (in_weight),
    .in_descend    (in_descend),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_character (out_character),
    .out_weight    (out_weight)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stable insertion sort reference.
  task automatic model(input logic [31:0] ch, input logic [39:0] w, input logic desc,
                       output logic [31:0] och, output logic [39:0] ow);
    int c[8];
    int v[8];
    int kc, kv, j;
    for (int i = 0; i < 8; i++) begin
      c[i] = int'(ch[(7-i)*4 +: 4]);
      v[i] = int'(w[(7-i)*5 +: 5]);
    end
    for (int i = 1; i < 8; i++) begin
      kc = c[i];
      kv = v[i];
      j  = i - 1;
      while (j >= 0 && (desc ? (v[j] < kv) : (v[j] > kv))) begin
        c[j+1] = c[j];
        v[j+1] = v[j];
        j--;
      end
      c[j+1] = kc;
      v[j+1] = kv;
    end
    for (int i = 0; i < 8; i++) begin
      och[(7-i)*4 +: 4] = 4'(c[i]);
      ow[(7-i)*5 +: 5]  = 5'(v[i]);
    end
  endtask

  task automatic send(input logic [31:0] ch, input logic [39:0] w, input logic desc, input int lat);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    in_valid     = 1'b1;
    in_character = ch;
    in_weight    = w;
    in_descend   = desc;
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    model(ch, w, desc, e.chr, e.wgt);
    e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_result(input int hold);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      check("result_timeout", 64'(out_valid), 64'd1);
      return;
    end
    if (e.lat >= 0) check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
    check("out_chars", 64'(out_character), 64'(e.chr));
    check("out_weights", 64'(out_weight), 64'(e.wgt));
    check("busy_ready", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid     = 1'b1;
      in_character = $urandom();
      in_weight    = {$urandom(), 8'($urandom())};
      in_descend   = h[0];
      @(negedge clk);
      check("hold_chars", 64'(out_character), 64'(e.chr));
      check("hold_weights", 64'(out_weight), 64'(e.wgt));
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_valid", 64'(out_valid), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ch;
    logic [39:0] w;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_character = '0;
    in_weight    = '0;
    in_descend   = 1'b0;
    out_ready    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_chars", 64'(out_character), 64'd0);
    check("rst_weights", 64'(out_weight), 64'd0);

    ch = 32'h0123_4567;
    w  = {5'd3, 5'd17, 5'd0, 5'd31, 5'd9, 5'd9, 5'd12, 5'd1};
    send(ch, w, 1'b1, -1);
    wait_result(0);
    check("spec_desc_chars", 64'(out_character), 64'd0);
    send(ch, w, 1'b0, -1);
    wait_result(0);

    // Spec vectors checked against literal results as well as the model.
    send(ch, w, 1'b1, -1);
    @(negedge clk);
    while (!out_valid && cyc - acc_cyc < 20) @(negedge clk);
    check("lit_desc_chars", 64'(out_character), 64'h3164_5072);
    check("lit_desc_wgts", 64'(out_weight),
          64'({5'd31, 5'd17, 5'd12, 5'd9, 5'd9, 5'd3, 5'd1, 5'd0}));
    wait_result(0);

    w = {5'd31, 5'd30, 5'd29, 5'd28, 5'd27, 5'd26, 5'd25, 5'd24};
    send(ch, w, 1'b1, 2);
    wait_result(0);

    w = {8{5'd13}};
    send(ch, w, 1'b0, 2);
    wait_result(0);

    w = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    send(ch, w, 1'b1, 8);
    wait_result(0);

    w = {5'd5, 5'd2, 5'd9, 5'd2, 5'd30, 5'd0, 5'd5, 5'd17};
    send(32'h89AB_CDEF, w, 1'b0, -1);
    wait_result(5);
    send(ch, w, 1'b1, -1);
    wait_result(0);

    // Reset lands on the edge that would perform pass 3.
    w = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    send(ch, w, 1'b1, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_chars", 64'(out_character), 64'd0);
    check("midrst_weights", 64'(out_weight), 64'd0);
    check("midrst_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready", 64'(in_ready), 64'd1);
    void'(sb.pop_front());
    w = {5'd7, 5'd7, 5'd1, 5'd20, 5'd3, 5'd7, 5'd0, 5'd31};
    send(ch, w, 1'b0, -1);
    wait_result(0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) w[(7-i)*5 +: 5] = 5'($urandom_range(0, 7));
      send(ch, w, r[0], -1);
      wait_result(r % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_sort_ip.md
# seq_sort_ip

Clocked, parametrised successor to the combinational weight sorter. It accepts a packed vector of NUM (character, weight) lanes over a valid/ready handshake and sorts the lanes by weight, ascending or descending per request. Sorting is iterative odd-even transposition with early termination, and ties are stable. It sits between the frequency/weight accumulation stage and the code-tree builder, and replaces the wide combinational sorter on the critical path.

## Interface
- NUM, 8: lane count, legal 2..16
- CHAR_W, 4: character field width
- WEIGHT_W, 5: weight field width (unsigned)

Ports:
- clk  in  1  rising-edge clock; the block has one clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request; equals (state==IDLE) && !rst
- in_character  in  NUM*CHAR_W  lane i at bits [(NUM-1-i)*CHAR_W +: CHAR_W], so lane 0 is the MSB slice
- in_weight  in  NUM*WEIGHT_W  lane i packed the same way as in_character
- in_descend  in  1  1 = largest weight first, 0 = smallest first; latched on accept
- out_valid  out  1  sorted result available
- out_ready  in  1  consumer takes the result
- out_character  out  NUM*CHAR_W  sorted characters, same lane packing; lane 0 is first in sort order
- out_weight  out  NUM*WEIGHT_W  sorted weights, same lane packing

## Operation
- FSM states: IDLE, SORT, DONE.
- IDLE:
  - On in_valid && in_ready, latch all lanes and in_descend, clear the pass counter, go to SORT.
- SORT: one pass per cycle.
  - Pass k even compares pairs (0,1),(2,3),…; pass k odd compares pairs (1,2),(3,4),…
  - Unpaired edge lanes hold their value.
  - Swap a pair only when it is strictly out of order: w[j] < w[j+1] in descend mode, w[j] > w[j+1] in ascend mode. Equal weights never swap, which makes the sort stable (lower input lane stays first).
  - Character and weight of a lane move together.
  - Track per-pass swap flags. After each pass, P = passes completed; go to DONE when P == NUM, or when P >= 2 and the last two passes both made no swap.
- DONE:
  - out_valid = 1; outputs drive the lane registers and hold stable.
  - On out_valid && out_ready, go to IDLE.
- in_valid outside IDLE is ignored; the request is not queued.
- Weight comparison is unsigned at WEIGHT_W bits. No arithmetic widening.
- Reset:
  - Takes effect at the next clk edge whenever rst is high, including mid-SORT and in DONE. A partial result is discarded.
  - After reset: state IDLE, out_valid 0, out_character 0, out_weight 0, pass counter 0, in_ready 1 once rst deasserts.

## Timing
- Accept at edge T.
- out_valid rises after edge T+P, where P is the number of passes: minimum 2 (input already sorted), maximum NUM.
- Result held indefinitely under out_ready=0.
- Handshake at edge U makes in_ready 1 after U. There is no back-to-back overlap, so a new request can be accepted at edge U+1 at the earliest.
- Throughput is one request per P+2 edges at best.
- in_ready and out_valid are pure functions of state and rst; no combinational path from inputs to outputs.

## Structure
- Package sort_pkg:
  - state encoding (IDLE/SORT/DONE)
  - default NUM/CHAR_W/WEIGHT_W constants
  - pass counter width $clog2(NUM+1)
- Sub-module sort_cmp_swap: one compare-and-swap cell.
  - Inputs: two (char, weight) pairs and descend.
  - Outputs: the ordered pair plus a swapped flag.
  - The top instantiates NUM-1 cells, enabling odd or even cells by pass parity.

## Test plan
All scenarios use NUM=8, CHAR_W=4, WEIGHT_W=5, chars lanes 0..7 = 0..7 unless stated.
- Weights 3,17,0,31,9,9,12,1, descend -> out chars 3,1,6,4,5,0,7,2; out weights 31,17,12,9,9,3,1,0 (tie keeps 4 before 5).
- Same weights, ascend -> out chars 2,7,0,4,5,6,1,3; out weights 0,1,3,9,9,12,17,31.
- Weights 31,30,…,24, descend -> out_valid 2 edges after accept; output identical to input. All weights equal -> same latency, identity order.
- Weights 0,1,…,7, descend -> out_valid exactly 8 edges after accept; chars reversed to 7,6,…,0.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid:
  - outputs stable, in_ready 0, no new capture;
  - out_ready=1 -> IDLE, in_ready 1 next cycle;
  - next request accepted and sorted correctly.
- Assert rst during pass 3 -> after that edge out_valid 0, outputs 0, in_ready 1 after deassert; a fresh request completes correctly.
